// File: rtl/pic8259_pkg.sv
// pic8259_pkg: command-state encodings and control-word bit positions shared by the 8259A front end
package pic8259_pkg;
  localparam logic [1:0] CMD_READY     = 2'd0;
  localparam logic [1:0] CMD_WAIT_ICW2 = 2'd1;
  localparam logic [1:0] CMD_WAIT_ICW3 = 2'd2;
  localparam logic [1:0] CMD_WAIT_ICW4 = 2'd3;
  localparam int ICW1_IC4   = 0;
  localparam int ICW1_SNGL  = 1;
  localparam int OCW_SEL_D3 = 3;
  localparam int CMD_SEL_D4 = 4;
  // Cascaded parts need ICW3 before the optional ICW4.
  function automatic logic [1:0] after_icw2(input logic sngl, input logic ic4);
    return !sngl ? CMD_WAIT_ICW3 : ic4 ? CMD_WAIT_ICW4 : CMD_READY;
  endfunction
endpackage

// File: rtl/bus_strobe_synchronizer.sv
// bus_strobe_synchronizer: N-stage flop chain bringing W asynchronous pins into the core clock together
module bus_strobe_synchronizer #(
  parameter int N = 2,
  parameter int W = 11
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [N-1:0][W-1:0] r_chain;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_chain <= '0;
    else          r_chain <= {r_chain[N-2:0], i_d};
  assign o_q = r_chain[N-1];
endmodule

// File: rtl/bus_control_logic.sv
// bus_control_logic: 8259A CPU bus front end - pin sync, write decode into ICW/OCW strobes, init sequencer
module bus_control_logic
  import pic8259_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2_4,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       address_for_read,
  output logic [1:0] command_state,
  output logic       initialization_complete
);
  logic [10:0] w_sync;
  logic        w_wr_s, w_rd_s, w_a0_s;
  logic [7:0]  w_d_s;
  logic        r_wr_prev, r_lat_a0, r_sngl, r_ic4, r_done, r_afr;
  logic [7:0]  r_lat_d, r_bus;
  logic [1:0]  r_state, w_state_nxt;
  logic [6:0]  r_stb, w_stb;
  logic        w_fall, w_ready, w_read;

  bus_strobe_synchronizer #(.N(SYNC_STAGES), .W(11)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     ({~chip_select_n & ~write_enable_n, ~chip_select_n & ~read_enable_n, address, data_bus_in}),
    .o_q     (w_sync)
  );
  assign {w_wr_s, w_rd_s, w_a0_s, w_d_s} = w_sync;

  assign w_fall  = r_wr_prev & ~w_wr_s;
  assign w_ready = r_state == CMD_READY;
  // Strobe order {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3}; OCW2/3 patterns mid-init decode to nothing.
  assign w_stb = {7{w_fall}} & {
    ~r_lat_a0 &  r_lat_d[CMD_SEL_D4],
     r_lat_a0 & (r_state == CMD_WAIT_ICW2),
     r_lat_a0 & (r_state == CMD_WAIT_ICW3),
     r_lat_a0 & (r_state == CMD_WAIT_ICW4),
     r_lat_a0 &  w_ready,
    ~r_lat_a0 & ~r_lat_d[CMD_SEL_D4] & ~r_lat_d[OCW_SEL_D3] & w_ready,
    ~r_lat_a0 & ~r_lat_d[CMD_SEL_D4] &  r_lat_d[OCW_SEL_D3] & w_ready};
  assign w_state_nxt = w_stb[6] ? CMD_WAIT_ICW2 :
                       w_stb[5] ? after_icw2(r_sngl, r_ic4) :
                       w_stb[4] ? (r_ic4 ? CMD_WAIT_ICW4 : CMD_READY) :
                       w_stb[3] ? CMD_READY : r_state;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wr_prev <= 1'b0;
      r_lat_a0  <= 1'b0;
      r_lat_d   <= '0;
      r_bus     <= '0;
      r_stb     <= '0;
      r_state   <= CMD_READY;
      r_sngl    <= 1'b0;
      r_ic4     <= 1'b0;
      r_done    <= 1'b0;
      r_afr     <= 1'b0;
    end else begin
      r_wr_prev <= w_wr_s;
      r_lat_a0  <= w_wr_s ? w_a0_s : r_lat_a0;
      r_lat_d   <= w_wr_s ? w_d_s : r_lat_d;
      r_bus     <= w_fall ? r_lat_d : r_bus;
      r_stb     <= w_stb;
      r_state   <= w_state_nxt;
      r_sngl    <= w_stb[6] ? r_lat_d[ICW1_SNGL] : r_sngl;
      r_ic4     <= w_stb[6] ? r_lat_d[ICW1_IC4] : r_ic4;
      r_done    <= w_stb[6] ? 1'b0 : (!w_ready && w_state_nxt == CMD_READY) ? 1'b1 : r_done;
      r_afr     <= w_read ? w_a0_s : r_afr;
    end

  assign w_read = w_rd_s & ~w_wr_s;

  assign internal_data_bus              = r_bus;
  assign write_initial_command_word_1   = r_stb[6];
  assign write_initial_command_word_2   = r_stb[5];
  assign write_initial_command_word_3   = r_stb[4];
  assign write_initial_command_word_4   = r_stb[3];
  assign write_initial_command_word_2_4 = |r_stb[5:3];
  assign write_operation_control_word_1 = r_stb[2];
  assign write_operation_control_word_2 = r_stb[1];
  assign write_operation_control_word_3 = r_stb[0];
  assign read                           = w_read;
  assign address_for_read               = w_read ? w_a0_s : r_afr;
  assign command_state                  = r_state;
  assign initialization_complete        = r_done;
endmodule

// File: tb/tb_bus_control_logic.sv
// tb_bus_control_logic: scoreboard bench for the 8259A bus front end against a queue-based init model
module tb_bus_control_logic;
  localparam int SS = 2;
  logic clock = 0, reset_n = 0, cs_n = 1, rd_n = 1, wr_n = 1, a0 = 0;
  logic [7:0] din = 0;
  logic [7:0] bus;
  logic icw1, icw24, icw2, icw3, icw4, ocw1, ocw2, ocw3, rd, afr, done;
  logic [1:0] st;

  bus_control_logic #(.SYNC_STAGES(SS)) dut (
    .clock(clock), .reset_n(reset_n), .chip_select_n(cs_n), .read_enable_n(rd_n),
    .write_enable_n(wr_n), .address(a0), .data_bus_in(din), .internal_data_bus(bus),
    .write_initial_command_word_1(icw1), .write_initial_command_word_2_4(icw24),
    .write_initial_command_word_2(icw2), .write_initial_command_word_3(icw3),
    .write_initial_command_word_4(icw4), .write_operation_control_word_1(ocw1),
    .write_operation_control_word_2(ocw2), .write_operation_control_word_3(ocw3),
    .read(rd), .address_for_read(afr), .command_state(st), .initialization_complete(done));

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  typedef struct {int kind; logic [7:0] bus; int st; bit done; int due;} exp_t;
  exp_t sb[$];
  int pend[$];
  bit m_done = 0;
  logic [7:0] m_bus = 0;
  logic [6:0] stb;
  assign stb = {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Remaining ICWs of the current init sequence; empty means READY.
  function automatic int m_state();
    return pend.size() == 0 ? 0 : pend[0] - 1;
  endfunction

  // kind: 1..4 = ICW1..ICW4, 5..7 = OCW1..OCW3, 0 = dropped
  task automatic model(input bit ma0, input logic [7:0] d, output int kind);
    m_bus = d;
    kind = 0;
    if (!ma0 && d[4]) begin
      kind = 1;
      pend.delete();
      pend.push_back(2);
      if (!d[1]) pend.push_back(3);
      if (d[0]) pend.push_back(4);
      m_done = 0;
    end else if (pend.size() > 0) begin
      if (ma0) begin
        kind = pend.pop_front();
        if (pend.size() == 0) m_done = 1;
      end
    end else kind = ma0 ? 5 : d[3] ? 7 : 6;
  endtask

  function automatic int stb_kind(input logic [6:0] s);
    for (int i = 0; i < 7; i++) if (s[6-i]) return i + 1;
    return 0;
  endfunction

  task automatic push_exp(input bit ma0, input logic [7:0] d);
    exp_t e;
    int k;
    model(ma0, d, k);
    if (k != 0) begin
      e.kind = k; e.bus = d; e.st = m_state(); e.done = m_done; e.due = cyc + SS + 1;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (stb != 0) begin
        chk("onehot", $countones(stb), 1);
        chk("or_2_4", icw24, icw2 | icw3 | icw4);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pulse actual=%b expected=none at cycle %0d", stb, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", stb_kind(stb), e.kind);
          chk("pulse_bus", bus, e.bus);
          chk("pulse_state", st, e.st);
          chk("pulse_init", done, e.done);
          chk("pulse_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic wr(input bit ma0, input logic [7:0] d, input int hold, input bit cs_first);
    @(negedge clock);
    cs_n = 0; wr_n = 0; a0 = ma0; din = d;
    repeat (hold) @(negedge clock);
    if (cs_first) cs_n = 1; else wr_n = 1;
    push_exp(ma0, d);
    din = 8'($urandom); a0 = 1'($urandom);
    @(negedge clock);
    cs_n = 1; wr_n = 1;
    repeat (5) @(negedge clock);
    chk("bus", bus, m_bus);
    chk("state", st, m_state());
    chk("init", done, m_done);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus"}, bus, 0);
    chk({tag, "_strobes"}, {stb, icw24}, 0);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_init"}, done, 0);
    chk({tag, "_read"}, {rd, afr}, 0);
  endtask

  initial begin
    #1 check_all_zero("reset");
    repeat (3) @(negedge clock);
    reset_n = 1;
    repeat (2) @(negedge clock);
    // single, IC4
    wr(0, 8'h13, 2, 0); wr(1, 8'h20, 3, 0); wr(1, 8'h01, 2, 0);
    // cascade, IC4
    wr(0, 8'h11, 2, 0); wr(1, 8'h08, 2, 0); wr(1, 8'h04, 2, 0); wr(1, 8'h03, 2, 0);
    // OCW1..3 in READY
    wr(1, 8'hFB, 2, 0); wr(0, 8'h20, 2, 0); wr(0, 8'h0B, 3, 0);
    // dropped OCW2 mid-init, then ICW1 restart in WAIT_ICW3
    wr(0, 8'h11, 2, 0); wr(0, 8'h20, 2, 0); wr(1, 8'h08, 2, 0);
    wr(0, 8'h12, 2, 0); wr(1, 8'h30, 2, 0);
    // read path, then write wins over read
    @(negedge clock); cs_n = 0; rd_n = 0; a0 = 1;
    @(negedge clock); chk("read_lat1", rd, 0);
    @(negedge clock); chk("read_on", rd, 1); chk("afr_on", afr, 1);
    wr_n = 0; din = 8'h55;
    repeat (2) @(negedge clock); chk("read_vs_write", rd, 0);
    wr_n = 1; push_exp(1, 8'h55);
    repeat (5) @(negedge clock); chk("read_back", rd, 1); chk("sb_rw", sb.size(), 0);
    rd_n = 1; cs_n = 1; a0 = 0;
    repeat (3) @(negedge clock); chk("read_off", rd, 0); chk("afr_hold", afr, 1);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(3) == 0) d = (d | 8'h10);
      wr(1'($urandom), d, $urandom_range(5, 2), $urandom_range(3) == 0);
    end
    // async reset mid-sequence with WR# held low
    wr(0, 8'h11, 2, 0); wr(1, 8'h08, 2, 0);
    chk("pre_reset_state", st, 2);
    @(negedge clock); cs_n = 0; wr_n = 0; a0 = 1; din = 8'h04;
    repeat (3) @(negedge clock);
    #2 reset_n = 0;
    #1 check_all_zero("async_reset");
    pend.delete(); m_done = 0; m_bus = 0; sb.delete();
    cs_n = 1; wr_n = 1;
    @(negedge clock); reset_n = 1;
    repeat (10) @(negedge clock);
    check_all_zero("post_reset");
    chk("post_reset_sb", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
